tfhe_pbs_scheduler: RTL and testbench
=====================================

Name: tfhe_pbs_scheduler

Overview:
- Queues host-issued PBS job descriptors and runs them one at a time on the TFHE processor.
- Drives the processor's start_pbs, tfhe_reset_n, hbm_select and host write address/length lines.
- Replaces direct register-bit control of those lines, sitting between the AXI-Lite register file and the TFHE core.
- Provides per-job timeout, abort and a completion stream with status.

Parameters:
ADDR_W, 32, descriptor address width
LEN_W, 32, descriptor length width
DEPTH, 4, job FIFO entries (power of 2, >=2)
TIMEOUT_W, 24, timeout counter width
SETTLE_CYCLES, 4, cycles HBM is switched to the core with core held in reset before start (>=1)

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  asynchronous, active-high reset
job_valid  in  1  descriptor offered
job_ready  out  1  FIFO can accept (= !full)
job_rd_addr  in  ADDR_W  ciphertext source address
job_rd_len  in  LEN_W  source length
job_wr_addr  in  ADDR_W  result destination address
job_wr_len  in  LEN_W  result length
timeout_cycles  in  TIMEOUT_W  per-job limit; 0 disables timeout
abort  in  1  level; terminates the active job
pbs_busy  in  1  core busy
pbs_done  in  1  core finished (level)
start_pbs  out  1  core start
tfhe_reset_n  out  1  core reset, active low
hbm_select  out  2  00 host, 01 TFHE core; 10/11 never driven
host_rd_addr  out  ADDR_W  active job source address
host_rd_len  out  LEN_W  active job source length
host_wr_addr  out  ADDR_W  active job destination address
host_wr_len  out  LEN_W  active job destination length
cpl_valid  out  1  completion available
cpl_ready  in  1  completion accepted
cpl_status  out  2  00 ok, 01 timeout, 10 aborted
cpl_rd_addr  out  ADDR_W  job identifier (its rd_addr)
queue_level  out  $clog2(DEPTH)+1  FIFO occupancy
idle  out  1  state==IDLE and FIFO empty

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE. Outputs: start_pbs=0, tfhe_reset_n=0, hbm_select=00, cpl_valid=0, cpl_status=00, all address/length outputs 0, queue_level=0, idle=1, job_ready=1.
- Reset mid-job drops the job with no completion.
- FIFO: push on job_valid&&job_ready. Pop happens only on the IDLE->LOAD transition. Push and pop in the same cycle keep the level. A push when full is impossible because job_ready=0.
- All control outputs are registered, Moore-decoded from the state.
- IDLE: hbm_select=00, tfhe_reset_n=0. Goes to LOAD if queue_level!=0. abort ignored.
- LOAD (1 cycle): pops the FIFO head into the host_* registers, clears the status register, goes to SETTLE.
- SETTLE: hbm_select=01, tfhe_reset_n=0, counts SETTLE_CYCLES cycles, then START.
- START: hbm_select=01, tfhe_reset_n=1, start_pbs=1. Timeout counter cleared on entry. Goes to RUN on pbs_busy.
- RUN: same outputs as START.
- Termination in START or RUN, priority done > abort > timeout:
  - pbs_done: status 00, go to DRAIN.
  - abort: status 10, go to DRAIN.
  - timeout_cycles!=0 and counter==timeout_cycles-1: status 01, go to DRAIN.
- Timeout counter: increments every START/RUN cycle and saturates; it does not wrap.
- abort in LOAD/SETTLE: status 10, go to DRAIN.
- DRAIN: start_pbs=0, tfhe_reset_n=0, hbm_select=00. Stays at least 1 cycle. Goes to CPL when pbs_busy=0.
- CPL: cpl_valid=1. cpl_status and cpl_rd_addr stay stable until cpl_ready. Goes to IDLE on cpl_valid&&cpl_ready; that cycle's cpl_valid is still 1. abort ignored.
- host_* outputs hold the last job's values until the next LOAD.
- Latency: for a push at edge 0 into an empty, idle scheduler, LOAD is at cycle 1, SETTLE covers cycles 2..SETTLE_CYCLES+1, and start_pbs first rises at cycle SETTLE_CYCLES+2.
- Back-to-back jobs: IDLE always lasts 1 cycle between jobs.

Test Plan:
- Single job: push rd_addr=0x1000, wr_addr=0x2000. Core raises busy 3 cycles after start and done 10 cycles later. Required: start_pbs rises at cycle 6 (SETTLE_CYCLES=4); DRAIN; cpl_status=00, cpl_rd_addr=0x1000; hbm_select 00->01->00; idle=1 afterwards.
- Fill and overflow: with cpl_ready=0 and no core response, push 5 jobs. Required: job_ready=0 after 4 queued; after the first job is popped queue_level=3 and job_ready=1; the 5th push is accepted only then; FIFO order preserved across completions.
- Timeout: timeout_cycles=20, core never asserts done. Required: DRAIN entered exactly 20 cycles after entering START; cpl_status=01; tfhe_reset_n=0 in DRAIN.
- Same-cycle events: pbs_done and abort asserted in the same RUN cycle -> cpl_status=00. abort asserted in SETTLE -> start_pbs never rises, cpl_status=10.
- Completion backpressure: hold cpl_ready=0 for 15 cycles. Required: cpl_valid and its fields stay stable; the next queued job does not start until the handshake completes.
- Reset mid-RUN with 2 jobs queued: assert S_AXI_ARESET asynchronously. Required: all outputs reach reset values immediately, queue_level=0, no completion is emitted.

Source files
------------

// File: rtl/tfhe_pbs_scheduler.sv
// tfhe_pbs_scheduler: queues PBS job descriptors and sequences them one at a time on the TFHE core,
// owning start_pbs, core reset, HBM routing and host address/length lines, with timeout, abort and completions.
module tfhe_pbs_scheduler #(
  parameter int ADDR_W        = 32,
  parameter int LEN_W         = 32,
  parameter int DEPTH         = 4,
  parameter int TIMEOUT_W     = 24,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESET,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [ADDR_W-1:0]          job_rd_addr,
  input  logic [LEN_W-1:0]           job_rd_len,
  input  logic [ADDR_W-1:0]          job_wr_addr,
  input  logic [LEN_W-1:0]           job_wr_len,
  input  logic [TIMEOUT_W-1:0]       timeout_cycles,
  input  logic                       abort,
  input  logic                       pbs_busy,
  input  logic                       pbs_done,
  output logic                       start_pbs,
  output logic                       tfhe_reset_n,
  output logic [1:0]                 hbm_select,
  output logic [ADDR_W-1:0]          host_rd_addr,
  output logic [LEN_W-1:0]           host_rd_len,
  output logic [ADDR_W-1:0]          host_wr_addr,
  output logic [LEN_W-1:0]           host_wr_len,
  output logic                       cpl_valid,
  input  logic                       cpl_ready,
  output logic [1:0]                 cpl_status,
  output logic [ADDR_W-1:0]          cpl_rd_addr,
  output logic [$clog2(DEPTH):0]     queue_level,
  output logic                       idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PW:0] FULL = DEPTH;
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] T_ONE = 1;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, START, RUN, DRAIN, CPL} state_t;
  state_t st, nxt;
  logic [ADDR_W-1:0] rd_addr_m [DEPTH];
  logic [ADDR_W-1:0] wr_addr_m [DEPTH];
  logic [LEN_W-1:0] rd_len_m [DEPTH];
  logic [LEN_W-1:0] wr_len_m [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] count;
  logic [SW-1:0] scnt;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [1:0] status;
  logic push, pop, active, tmo, term;
  assign job_ready = count != FULL;
  assign push = job_valid && job_ready;
  assign pop = st == IDLE && count != '0;
  assign active = st == START || st == RUN;
  assign tmo = timeout_cycles != '0 && tcnt == timeout_cycles - T_ONE;
  assign term = pbs_done || abort || tmo;
  assign idle = st == IDLE && count == '0;
  assign queue_level = count;
  assign cpl_status = status;
  assign cpl_rd_addr = host_rd_addr;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:       nxt = pop ? LOAD : IDLE;
      LOAD:       nxt = abort ? DRAIN : SETTLE;
      SETTLE:     nxt = abort ? DRAIN : (scnt == S_LAST) ? START : SETTLE;
      START, RUN: nxt = term ? DRAIN : (st == RUN || pbs_busy) ? RUN : START;
      DRAIN:      nxt = pbs_busy ? DRAIN : CPL;
      CPL:        nxt = cpl_ready ? IDLE : CPL;
      default:    nxt = IDLE;
    endcase
  end
  // descriptor storage needs no reset; occupancy is tracked by count
  always_ff @(posedge S_AXI_ACLK) begin
    if (push) begin
      rd_addr_m[wptr] <= job_rd_addr;
      wr_addr_m[wptr] <= job_wr_addr;
      rd_len_m[wptr] <= job_rd_len;
      wr_len_m[wptr] <= job_wr_len;
    end
  end
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      st <= IDLE;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      scnt <= '0;
      tcnt <= '0;
      status <= 2'b00;
      host_rd_addr <= '0;
      host_rd_len <= '0;
      host_wr_addr <= '0;
      host_wr_len <= '0;
      start_pbs <= 1'b0;
      tfhe_reset_n <= 1'b0;
      hbm_select <= 2'b00;
      cpl_valid <= 1'b0;
    end else begin
      st <= nxt;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        host_rd_addr <= rd_addr_m[rptr];
        host_rd_len <= rd_len_m[rptr];
        host_wr_addr <= wr_addr_m[rptr];
        host_wr_len <= wr_len_m[rptr];
      end
      scnt <= (st == SETTLE) ? scnt + 1'b1 : '0;
      tcnt <= active ? (&tcnt ? tcnt : tcnt + T_ONE) : '0;
      // completion precedence: done over abort over timeout
      status <= pop ? 2'b00 :
                ((st == LOAD || st == SETTLE) && abort) ? 2'b10 :
                (active && term) ? (pbs_done ? 2'b00 : abort ? 2'b10 : 2'b01) : status;
      start_pbs <= nxt == START || nxt == RUN;
      tfhe_reset_n <= nxt == START || nxt == RUN;
      hbm_select <= {1'b0, nxt == SETTLE || nxt == START || nxt == RUN};
      cpl_valid <= nxt == CPL;
    end
  end
endmodule

// File: tb/tb_tfhe_pbs_scheduler.sv
// tb_tfhe_pbs_scheduler: directed scenario tests for the PBS job scheduler.
module tb_tfhe_pbs_scheduler;
  logic clk = 0, rst = 0;
  logic job_valid = 0, job_ready, abort = 0, pbs_busy = 0, pbs_done = 0, cpl_ready = 1;
  logic [31:0] job_rd_addr = 0, job_rd_len = 0, job_wr_addr = 0, job_wr_len = 0;
  logic [23:0] timeout_cycles = 0;
  logic start_pbs, tfhe_reset_n, cpl_valid, idle;
  logic [1:0] hbm_select, cpl_status;
  logic [31:0] host_rd_addr, host_rd_len, host_wr_addr, host_wr_len, cpl_rd_addr;
  logic [2:0] queue_level;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  tfhe_pbs_scheduler #(.ADDR_W(32), .LEN_W(32), .DEPTH(4), .TIMEOUT_W(24), .SETTLE_CYCLES(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_rd_addr(job_rd_addr), .job_rd_len(job_rd_len), .job_wr_addr(job_wr_addr), .job_wr_len(job_wr_len),
    .timeout_cycles(timeout_cycles), .abort(abort), .pbs_busy(pbs_busy), .pbs_done(pbs_done),
    .start_pbs(start_pbs), .tfhe_reset_n(tfhe_reset_n), .hbm_select(hbm_select),
    .host_rd_addr(host_rd_addr), .host_rd_len(host_rd_len), .host_wr_addr(host_wr_addr), .host_wr_len(host_wr_len),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_status(cpl_status), .cpl_rd_addr(cpl_rd_addr),
    .queue_level(queue_level), .idle(idle));
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set_job(input logic [31:0] a);
    job_rd_addr = a;
    job_wr_addr = a + 32'h1000;
    job_rd_len = 32'h100;
    job_wr_len = 32'h80;
  endtask
  task automatic push(input logic [31:0] a);
    set_job(a);
    job_valid = 1;
    tick(1);
    job_valid = 0;
  endtask
  task automatic test_reset;
    #1 rst = 1;
    #1;
    checks++;
    if ({start_pbs, tfhe_reset_n, hbm_select, cpl_valid, cpl_status, idle, job_ready, queue_level} !== 12'b0_0_00_0_00_1_1_000) begin
      errs++;
      $display("FAIL reset_ctrl: got %b want 000000011000", {start_pbs, tfhe_reset_n, hbm_select, cpl_valid, cpl_status, idle, job_ready, queue_level});
    end
    checks++;
    if ({host_rd_addr, host_rd_len, host_wr_addr, host_wr_len} !== 128'h0) begin
      errs++;
      $display("FAIL reset_host: got %h want 0", {host_rd_addr, host_rd_len, host_wr_addr, host_wr_len});
    end
    @(negedge clk) rst = 0;
    tick(1);
  endtask
  task automatic test_single_job;
    push(32'h1000);
    checks++;
    if ({queue_level, idle} !== 4'b001_0) begin
      errs++;
      $display("FAIL single_queued: got level=%0d idle=%b want 1 0", queue_level, idle);
    end
    tick(1);
    checks++;
    if ({host_rd_addr, host_wr_addr, queue_level, hbm_select, start_pbs} !== {32'h1000, 32'h2000, 3'd0, 2'b00, 1'b0}) begin
      errs++;
      $display("FAIL single_load: got rd=%h wr=%h lvl=%0d hbm=%b start=%b want 1000 2000 0 00 0", host_rd_addr, host_wr_addr, queue_level, hbm_select, start_pbs);
    end
    for (int c = 2; c <= 5; c++) begin
      tick(1);
      checks++;
      if ({hbm_select, tfhe_reset_n, start_pbs} !== 4'b01_0_0) begin
        errs++;
        $display("FAIL single_settle%0d: got hbm=%b rstn=%b start=%b want 01 0 0", c, hbm_select, tfhe_reset_n, start_pbs);
      end
    end
    tick(1);
    checks++;
    if ({hbm_select, tfhe_reset_n, start_pbs} !== 4'b01_1_1) begin
      errs++;
      $display("FAIL single_start6: got hbm=%b rstn=%b start=%b want 01 1 1", hbm_select, tfhe_reset_n, start_pbs);
    end
    tick(2);
    pbs_busy = 1;
    tick(10);
    pbs_done = 1;
    tick(1);
    checks++;
    if ({start_pbs, tfhe_reset_n, hbm_select, cpl_valid} !== 5'b0_0_00_0) begin
      errs++;
      $display("FAIL single_drain: got start=%b rstn=%b hbm=%b cplv=%b want 0 0 00 0", start_pbs, tfhe_reset_n, hbm_select, cpl_valid);
    end
    pbs_busy = 0;
    pbs_done = 0;
    tick(1);
    checks++;
    if ({cpl_valid, cpl_status, cpl_rd_addr} !== {1'b1, 2'b00, 32'h1000}) begin
      errs++;
      $display("FAIL single_cpl: got v=%b st=%b addr=%h want 1 00 1000", cpl_valid, cpl_status, cpl_rd_addr);
    end
    tick(1);
    checks++;
    if ({cpl_valid, idle} !== 2'b01) begin
      errs++;
      $display("FAIL single_idle: got cplv=%b idle=%b want 0 1", cpl_valid, idle);
    end
  endtask
  task automatic test_timeout;
    timeout_cycles = 24'd20;
    push(32'h3000);
    tick(6);
    pbs_busy = 1;
    tick(19);
    checks++;
    if (start_pbs !== 1'b1) begin
      errs++;
      $display("FAIL timeout_early: got start=%b want 1 at 19 cycles after START", start_pbs);
    end
    tick(1);
    checks++;
    if ({start_pbs, tfhe_reset_n, hbm_select} !== 4'b0_0_00) begin
      errs++;
      $display("FAIL timeout_drain: got start=%b rstn=%b hbm=%b want 0 0 00", start_pbs, tfhe_reset_n, hbm_select);
    end
    pbs_busy = 0;
    tick(1);
    checks++;
    if ({cpl_valid, cpl_status, cpl_rd_addr} !== {1'b1, 2'b01, 32'h3000}) begin
      errs++;
      $display("FAIL timeout_cpl: got v=%b st=%b addr=%h want 1 01 3000", cpl_valid, cpl_status, cpl_rd_addr);
    end
    tick(1);
    timeout_cycles = 0;
  endtask
  task automatic test_same_cycle;
    push(32'h4000);
    tick(6);
    pbs_busy = 1;
    tick(1);
    pbs_done = 1;
    abort = 1;
    tick(1);
    pbs_done = 0;
    abort = 0;
    pbs_busy = 0;
    tick(1);
    checks++;
    if ({cpl_valid, cpl_status, cpl_rd_addr} !== {1'b1, 2'b00, 32'h4000}) begin
      errs++;
      $display("FAIL done_vs_abort: got v=%b st=%b addr=%h want 1 00 4000", cpl_valid, cpl_status, cpl_rd_addr);
    end
    tick(1);
    push(32'h5000);
    tick(2);
    abort = 1;
    tick(1);
    abort = 0;
    checks++;
    if ({start_pbs, hbm_select, tfhe_reset_n} !== 4'b0_00_0) begin
      errs++;
      $display("FAIL settle_abort_drain: got start=%b hbm=%b rstn=%b want 0 00 0", start_pbs, hbm_select, tfhe_reset_n);
    end
    tick(1);
    checks++;
    if ({cpl_valid, cpl_status, cpl_rd_addr, start_pbs} !== {1'b1, 2'b10, 32'h5000, 1'b0}) begin
      errs++;
      $display("FAIL settle_abort_cpl: got v=%b st=%b addr=%h start=%b want 1 10 5000 0", cpl_valid, cpl_status, cpl_rd_addr, start_pbs);
    end
    tick(1);
    checks++;
    if (idle !== 1'b1) begin
      errs++;
      $display("FAIL settle_abort_idle: got %b want 1", idle);
    end
  endtask
  task automatic test_backpressure;
    cpl_ready = 0;
    push(32'h6000);
    push(32'h7000);
    tick(5);
    pbs_done = 1;
    tick(1);
    pbs_done = 0;
    tick(1);
    for (int c = 0; c < 15; c++) begin
      tick(1);
      checks++;
      if ({cpl_valid, cpl_status, cpl_rd_addr, queue_level, start_pbs} !== {1'b1, 2'b00, 32'h6000, 3'd1, 1'b0}) begin
        errs++;
        $display("FAIL bp_hold%0d: got v=%b st=%b addr=%h lvl=%0d start=%b want 1 00 6000 1 0", c, cpl_valid, cpl_status, cpl_rd_addr, queue_level, start_pbs);
      end
    end
    cpl_ready = 1;
    tick(1);
    checks++;
    if ({cpl_valid, host_rd_addr} !== {1'b0, 32'h6000}) begin
      errs++;
      $display("FAIL bp_release: got v=%b host=%h want 0 6000", cpl_valid, host_rd_addr);
    end
    tick(1);
    checks++;
    if ({host_rd_addr, queue_level} !== {32'h7000, 3'd0}) begin
      errs++;
      $display("FAIL bp_next_load: got host=%h lvl=%0d want 7000 0", host_rd_addr, queue_level);
    end
    abort = 1;
    tick(1);
    abort = 0;
    tick(1);
    checks++;
    if ({cpl_valid, cpl_status, cpl_rd_addr} !== {1'b1, 2'b10, 32'h7000}) begin
      errs++;
      $display("FAIL load_abort_cpl: got v=%b st=%b addr=%h want 1 10 7000", cpl_valid, cpl_status, cpl_rd_addr);
    end
    tick(1);
  endtask
  task automatic test_fill;
    logic [31:0] exp_addr [6];
    for (int i = 0; i < 6; i++) exp_addr[i] = 32'hA000 + 32'h100 * i;
    cpl_ready = 0;
    push(exp_addr[0]);
    tick(6);
    for (int i = 1; i <= 4; i++) push(exp_addr[i]);
    checks++;
    if ({job_ready, queue_level} !== {1'b0, 3'd4}) begin
      errs++;
      $display("FAIL fill_full: got ready=%b lvl=%0d want 0 4", job_ready, queue_level);
    end
    set_job(exp_addr[5]);
    job_valid = 1;
    abort = 1;
    tick(1);
    abort = 0;
    tick(1);
    checks++;
    if ({cpl_valid, cpl_status, cpl_rd_addr, queue_level} !== {1'b1, 2'b10, exp_addr[0], 3'd4}) begin
      errs++;
      $display("FAIL fill_first_cpl: got v=%b st=%b addr=%h lvl=%0d want 1 10 %h 4", cpl_valid, cpl_status, cpl_rd_addr, queue_level, exp_addr[0]);
    end
    cpl_ready = 1;
    tick(1);
    cpl_ready = 0;
    tick(1);
    checks++;
    if ({queue_level, job_ready, host_rd_addr} !== {3'd3, 1'b1, exp_addr[1]}) begin
      errs++;
      $display("FAIL fill_after_pop: got lvl=%0d ready=%b host=%h want 3 1 %h", queue_level, job_ready, host_rd_addr, exp_addr[1]);
    end
    tick(1);
    job_valid = 0;
    checks++;
    if (queue_level !== 3'd4) begin
      errs++;
      $display("FAIL fill_fifth_push: got lvl=%0d want 4", queue_level);
    end
    abort = 1;
    for (int i = 1; i <= 5; i++) begin
      for (int c = 0; c < 20 && !cpl_valid; c++) tick(1);
      checks++;
      if ({cpl_valid, cpl_rd_addr} !== {1'b1, exp_addr[i]}) begin
        errs++;
        $display("FAIL fill_order%0d: got v=%b addr=%h want 1 %h", i, cpl_valid, cpl_rd_addr, exp_addr[i]);
      end
      cpl_ready = 1;
      tick(1);
      cpl_ready = 0;
    end
    abort = 0;
    cpl_ready = 1;
    checks++;
    if ({idle, queue_level} !== {1'b1, 3'd0}) begin
      errs++;
      $display("FAIL fill_empty: got idle=%b lvl=%0d want 1 0", idle, queue_level);
    end
  endtask
  task automatic test_reset_mid_run;
    int seen;
    seen = 0;
    push(32'hB000);
    tick(6);
    pbs_busy = 1;
    tick(1);
    push(32'hC000);
    push(32'hD000);
    checks++;
    if ({queue_level, start_pbs} !== {3'd2, 1'b1}) begin
      errs++;
      $display("FAIL rst_pre: got lvl=%0d start=%b want 2 1", queue_level, start_pbs);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({start_pbs, tfhe_reset_n, hbm_select, cpl_valid, cpl_status, idle, job_ready, queue_level, host_rd_addr} !== {12'b0_0_00_0_00_1_1_000, 32'h0}) begin
      errs++;
      $display("FAIL rst_async: got ctrl=%b host=%h want 000000011000 0", {start_pbs, tfhe_reset_n, hbm_select, cpl_valid, cpl_status, idle, job_ready, queue_level}, host_rd_addr);
    end
    pbs_busy = 0;
    @(negedge clk) rst = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (cpl_valid) seen++;
    end
    checks++;
    if ({seen, idle, queue_level} !== {32'd0, 1'b1, 3'd0}) begin
      errs++;
      $display("FAIL rst_no_cpl: got cpl_cycles=%0d idle=%b lvl=%0d want 0 1 0", seen, idle, queue_level);
    end
  endtask
  initial begin
    test_reset;
    test_single_job;
    test_timeout;
    test_same_cycle;
    test_backpressure;
    test_fill;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
